pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central pipeline sequencing controller for the RV32 five-stage core (IF/ID/EX/MEM/WB). It consumes per-stage decode results (register indices, load/store, branch/jump resolution, ebreak) and drives the enable and flush controls of the PC and every pipeline register. It also owns the data-memory request handshake, with a wait timeout, and the ebreak halt state. It adds a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive unanswered dmem cycles before a fault halt; 0 disables the timeout.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  core clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source registers.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rd  in  5  EX destination register.
- ex_reg_wen  in  1  EX writes the register file.
- ex_is_load  in  1  EX is a load (mem_ren & ~mem_wen).
- ex_redirect  in  1  EX resolved a taken branch, jal, or jalr.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_access  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- wb_valid  in  1  WB stage holds a real instruction.
- wb_ebreak  in  1  WB instruction is ebreak (32'h00100073).
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en  out  1 each  pipeline register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble into that register.
- dmem_req  out  1  data memory request.
- halted  out  1  core stopped.
- mem_err  out  1  halt was caused by a dmem timeout.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

## Operation
- States: RUN, MEM_WAIT, HALT (2-bit register). Registered state: wait_cnt and stall_cycles. All control outputs are combinational from the inputs and the registered state.
- Rule priority, highest first: rst > HALT > ebreak > mem-wait > redirect > load-use > normal.
- rst: all *_en=0, all flushes=1, dmem_req=0. Next state RUN; wait_cnt, stall_cycles, halted, and mem_err all 0.
- HALT: all *_en=0, all flushes=0, dmem_req=0, halted=1. Exit only by rst.
- ebreak (wb_valid & wb_ebreak, in RUN or MEM_WAIT):
  - pc_en and all *_en =0.
  - ifid_flush, idex_flush, exmem_flush =1; memwb_flush=0.
  - dmem_req=0.
  - Next state HALT with mem_err=0.
- dmem_req = mem_valid & mem_access, asserted in RUN and MEM_WAIT only.
- mem-wait (dmem_req & ~dmem_ready):
  - pc_en and all *_en =0.
  - memwb_flush=1; all other flushes 0.
  - Next state MEM_WAIT; wait_cnt increments.
  - If MEM_TIMEOUT≠0 and wait_cnt+1 == MEM_TIMEOUT: next state HALT with mem_err=1.
- dmem_ready while in MEM_WAIT: wait_cnt clears, next state RUN, and the other rules apply in the same cycle.
- redirect (ex_valid & ex_redirect):
  - pc_en, ifid_en, idex_en, exmem_en =1.
  - ifid_flush=1, idex_flush=1.
  - Suppresses load-use, because the ID instruction is killed.
- load-use, asserted when all of these hold:
  - id_valid & ex_valid & ex_is_load & ex_reg_wen & ex_rd≠0
  - and the ID instruction reads ex_rd: (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd).
  - Response: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1.
- normal: all *_en=1, all flushes 0.
- stall_cycles: +1 on every non-reset, non-HALT cycle with pc_en=0. This includes the ebreak cycle. Saturates at all-ones.
- A flush takes precedence over the enable of the same register.

## Timing
- Control outputs respond in the same cycle as their inputs (zero latency).
- State, wait_cnt, and counter updates take effect at the next rising clk.
- halted rises exactly 1 cycle after the ebreak cycle.
- Timeout: with MEM_TIMEOUT=N, HALT is entered after N consecutive not-ready request cycles. halted=1 on cycle N+1.
- rst asserted in mid-MEM_WAIT or in HALT returns to RUN on the next edge; wait_cnt and mem_err are cleared.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and clears ex_is_load.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, ex_reg_wen=1, id_rs2=5, id_use_rs2=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cycles 0->1. Repeat with ex_rd=0 -> no stall.
- Redirect with simultaneous load-use: ex_redirect=1 under the same hazard -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
- dmem wait: mem_access held with dmem_ready=0 for 3 cycles, then 1 -> all enables 0 and memwb_flush=1 for 3 cycles, state MEM_WAIT, then RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready tied 0 -> halted=1 and mem_err=1 on cycle 5; dmem_req=0 thereafter.
- ebreak: wb_ebreak=1 during a mem wait -> flushes ifid/idex/exmem, dmem_req=0, halted=1 next cycle, mem_err=0; rst then clears halted and returns to normal enables.
- Counter saturation: CNT_W=4, force 20 load-use stalls -> stall_cycles holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the RV32 five-stage core: stage enables and flushes,
// data-memory handshake with wait timeout, ebreak/fault halt and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wen,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_valid,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             wb_valid,
  input  logic             wb_ebreak,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam int          WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_C = 32'(MEM_TIMEOUT);

  state_t             state_r, state_nxt_s;
  logic [WAIT_W-1:0]  wait_r, wait_nxt_s, wait_inc_s;
  logic               mem_err_r, mem_err_nxt_s;
  logic [CNT_W-1:0]   stall_r;
  logic               mem_req_s, load_use_s, timeout_s, stall_inc_s;

  assign mem_req_s  = mem_valid & mem_access;
  assign load_use_s = id_valid & ex_valid & ex_is_load & ex_reg_wen & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // The wait counter saturates so a disabled timeout can never wrap into a false match.
  assign wait_inc_s = (wait_r == {WAIT_W{1'b1}}) ? wait_r : (wait_r + {{(WAIT_W-1){1'b0}}, 1'b1});
  assign timeout_s  = (TIMEOUT_C != 32'd0) && ((32'(wait_r) + 32'd1) == TIMEOUT_C);

  assign halted       = (state_r == ST_HALT);
  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_r;
  assign stall_inc_s  = ~rst & (state_r != ST_HALT) & ~pc_en;

  // Priority-ordered control decode and next-state selection.
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    dmem_req      = 1'b0;
    state_nxt_s   = state_r;
    wait_nxt_s    = wait_r;
    mem_err_nxt_s = mem_err_r;
    if (rst) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      memwb_flush   = 1'b1;
      state_nxt_s   = ST_RUN;
      wait_nxt_s    = {WAIT_W{1'b0}};
      mem_err_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (wb_valid & wb_ebreak) begin
            // Let the ebreak retire from WB; kill everything younger.
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            state_nxt_s   = ST_HALT;
            wait_nxt_s    = {WAIT_W{1'b0}};
            mem_err_nxt_s = 1'b0;
          end else begin
            dmem_req = mem_req_s;
            if (mem_req_s & ~dmem_ready) begin
              memwb_flush = 1'b1;
              wait_nxt_s  = wait_inc_s;
              if (timeout_s) begin
                state_nxt_s   = ST_HALT;
                mem_err_nxt_s = 1'b1;
              end else begin
                state_nxt_s = ST_MEM_WAIT;
              end
            end else begin
              wait_nxt_s  = {WAIT_W{1'b0}};
              state_nxt_s = ST_RUN;
              if (ex_valid & ex_redirect) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
              end else if (load_use_s) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
              end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_HALT;
        end
      endcase
    end
  end

  // State, wait counter, fault flag and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      wait_r    <= {WAIT_W{1'b0}};
      mem_err_r <= 1'b0;
      stall_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      wait_r    <= wait_nxt_s;
      mem_err_r <= mem_err_nxt_s;
      if (stall_inc_s && (stall_r != {CNT_W{1'b1}})) begin
        stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_r <= stall_r;
      end
    end
  end

endmodule
